// File: rtl/breakout_pkg.sv
// Shared types and widths for the breakout video path.
// Holds the renderer FSM state type, coordinate/colour widths and a
// coordinate helper used when scanning a box on screen.
package breakout_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;
  // One extra bit so box pixels past the right/bottom edge never wrap to 0.
  localparam int PIX_W    = COORD_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Screen coordinate of a box pixel, widened so overflow stays visible.
  function automatic logic [PIX_W-1:0] pix_add(input logic [COORD_W-1:0] base,
                                               input logic [COORD_W-1:0] off);
    return {1'b0, base} + {1'b0, off};
  endfunction

endpackage

// File: rtl/box_scanner.sv
// Row-major offset generator for a BALL_SIZE x BALL_SIZE box (dx fastest).
// Counters advance on step_i, wrap to (0,0) after the last pixel, and
// clear on restart_i; last_o flags the final pixel of the box.
module box_scanner
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               restart_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] dx_o,
  output logic [COORD_W-1:0] dy_o,
  output logic               last_o
);

  localparam int CNT_W = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;
  localparam logic [CNT_W-1:0] MAX_OFF = CNT_W'(BALL_SIZE - 1);

  logic [CNT_W-1:0] dx_q, dx_d;
  logic [CNT_W-1:0] dy_q, dy_d;

  // Next offset: restart wins, otherwise advance dx then dy, wrapping at the end.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (restart_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (step_i) begin
      if (dx_q == MAX_OFF) begin
        dx_d = '0;
        dy_d = (dy_q == MAX_OFF) ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  // Offset registers, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_o   = COORD_W'(dx_q);
  assign dy_o   = COORD_W'(dy_q);
  assign last_o = (dx_q == MAX_OFF) && (dy_q == MAX_OFF);

endmodule

// File: rtl/ball_renderer.sv
// Redraws the ball: erases the old box in BG_COLOR, draws the new one in
// BALL_COLOR, one pixel per clock; updates while busy are held (latest wins).
// Optional: `define RENDER_SKIP_SAME_EN to skip redraws of an unchanged position.
module ball_renderer
  import breakout_pkg::*;
#(
  parameter int                  BALL_SIZE  = 4,
  parameter int                  H_RES      = 640,
  parameter int                  V_RES      = 480,
  parameter logic [COLOUR_W-1:0] BG_COLOR   = 3'b000,
  parameter logic [COLOUR_W-1:0] BALL_COLOR = 3'b111
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  input  logic                update,
  output logic [COORD_W-1:0]  vga_x,
  output logic [COORD_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [PIX_W-1:0] H_LIM = PIX_W'(H_RES);
  localparam logic [PIX_W-1:0] V_LIM = PIX_W'(V_RES);

  state_t               state_q;
  logic [COORD_W-1:0]   new_x_q, new_y_q;
  logic [COORD_W-1:0]   old_x_q, old_y_q;
  logic                 old_vld_q;
  logic [COORD_W-1:0]   pend_x_q, pend_y_q;
  logic                 pend_vld_q;
  // Set when the pixel currently on the outputs is the last of its box.
  logic                 fin_q;
  logic [COORD_W-1:0]   vga_x_q, vga_y_q;
  logic [COLOUR_W-1:0]  colour_q;
  logic                 plot_q, busy_q, done_q;

  logic [COORD_W-1:0]   sc_dx, sc_dy;
  logic                 sc_last, sc_step, sc_restart;
  logic [COORD_W-1:0]   base_x, base_y;
  logic [PIX_W-1:0]     pix_x, pix_y;
  logic                 pix_ok;
  logic                 same_pos;

`ifdef RENDER_SKIP_SAME_EN
  assign same_pos = old_vld_q && (ball_x == old_x_q) && (ball_y == old_y_q);
`else
  assign same_pos = 1'b0;
`endif

  box_scanner #(
    .BALL_SIZE (BALL_SIZE)
  ) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .restart_i (sc_restart),
    .step_i    (sc_step),
    .dx_o      (sc_dx),
    .dy_o      (sc_dy),
    .last_o    (sc_last)
  );

  // Choose the box whose pixel is emitted at the next edge and drive the scanner.
  always_comb begin
    sc_step    = 1'b0;
    sc_restart = 1'b0;
    base_x     = new_x_q;
    base_y     = new_y_q;
    case (state_q)
      IDLE: begin
        if (update && !same_pos) begin
          sc_step = 1'b1;
          base_x  = old_vld_q ? old_x_q : ball_x;
          base_y  = old_vld_q ? old_y_q : ball_y;
        end else begin
          sc_restart = 1'b1;
        end
      end
      ERASE: begin
        sc_step = 1'b1;
        if (!fin_q) begin
          base_x = old_x_q;
          base_y = old_y_q;
        end
      end
      DRAW: begin
        sc_step = !fin_q;
      end
      DONE: begin
        // The box just drawn becomes the one erased by a pending redraw.
        if (update || pend_vld_q) sc_step = 1'b1;
        else                      sc_restart = 1'b1;
      end
      default: sc_restart = 1'b1;
    endcase
  end

  assign pix_x  = pix_add(base_x, sc_dx);
  assign pix_y  = pix_add(base_y, sc_dy);
  assign pix_ok = (pix_x < H_LIM) && (pix_y < V_LIM);

  // Renderer FSM with registered pixel outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      new_x_q    <= '0;
      new_y_q    <= '0;
      old_x_q    <= '0;
      old_y_q    <= '0;
      old_vld_q  <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_vld_q <= 1'b0;
      fin_q      <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      colour_q   <= BG_COLOR;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (update) begin
            new_x_q <= ball_x;
            new_y_q <= ball_y;
            busy_q  <= 1'b1;
            if (same_pos) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              plot_q   <= 1'b0;
              colour_q <= BG_COLOR;
            end else begin
              vga_x_q  <= pix_x[COORD_W-1:0];
              vga_y_q  <= pix_y[COORD_W-1:0];
              plot_q   <= pix_ok;
              fin_q    <= sc_last;
              colour_q <= old_vld_q ? BG_COLOR : BALL_COLOR;
              state_q  <= old_vld_q ? ERASE : DRAW;
            end
          end else begin
            plot_q   <= 1'b0;
            colour_q <= BG_COLOR;
            busy_q   <= 1'b0;
          end
        end
        ERASE: begin
          if (update) begin
            pend_x_q   <= ball_x;
            pend_y_q   <= ball_y;
            pend_vld_q <= 1'b1;
          end
          vga_x_q <= pix_x[COORD_W-1:0];
          vga_y_q <= pix_y[COORD_W-1:0];
          plot_q  <= pix_ok;
          fin_q   <= sc_last;
          if (fin_q) begin
            state_q  <= DRAW;
            colour_q <= BALL_COLOR;
          end
        end
        DRAW: begin
          if (update) begin
            pend_x_q   <= ball_x;
            pend_y_q   <= ball_y;
            pend_vld_q <= 1'b1;
          end
          if (fin_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            plot_q   <= 1'b0;
            colour_q <= BG_COLOR;
            fin_q    <= 1'b0;
          end else begin
            vga_x_q <= pix_x[COORD_W-1:0];
            vga_y_q <= pix_y[COORD_W-1:0];
            plot_q  <= pix_ok;
            fin_q   <= sc_last;
          end
        end
        DONE: begin
          old_x_q   <= new_x_q;
          old_y_q   <= new_y_q;
          old_vld_q <= 1'b1;
          if (update || pend_vld_q) begin
            // An update landing in this cycle is newer than the held one.
            new_x_q    <= update ? ball_x : pend_x_q;
            new_y_q    <= update ? ball_y : pend_y_q;
            pend_vld_q <= 1'b0;
            vga_x_q    <= pix_x[COORD_W-1:0];
            vga_y_q    <= pix_y[COORD_W-1:0];
            plot_q     <= pix_ok;
            fin_q      <= sc_last;
            colour_q   <= BG_COLOR;
            state_q    <= ERASE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 4: ball square edge in pixels.
REQ-002 SHALL have parameter H_RES, default 640: visible width in pixels.
REQ-003 SHALL have parameter V_RES, default 480: visible height in pixels.
REQ-004 SHALL have parameter BG_COLOR, default 3'b000: colour used for erase.
REQ-005 SHALL have parameter BALL_COLOR, default 3'b111: colour used for draw.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port ball_x, input, 10: new ball top-left X.
REQ-009 SHALL have port ball_y, input, 10: new ball top-left Y.
REQ-010 SHALL have port update, input, 1: one-cycle pulse; ball_x/ball_y are valid.
REQ-011 SHALL have port vga_x, output, 10: pixel X to the VGA adapter.
REQ-012 SHALL have port vga_y, output, 10: pixel Y to the VGA adapter.
REQ-013 SHALL have port vga_colour, output, 3: pixel colour.
REQ-014 SHALL have port plot, output, 1: pixel write strobe.
REQ-015 SHALL have port busy, output, 1: high while not in IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a redraw completes.

Function
REQ-017 SHALL implement FSM states IDLE, ERASE, DRAW, DONE; all outputs registered.
REQ-018 SHALL, on update in IDLE at cycle t, latch ball_x/ball_y as the new position and enter ERASE at t+1, or DRAW at t+1 if no old position is valid.
REQ-019 SHALL, in ERASE, plot BG_COLOR over the old-position box: one pixel per cycle, row-major (dx fastest), plot high for exactly BALL_SIZE*BALL_SIZE cycles, then enter DRAW.
REQ-020 SHALL, in DRAW, plot BALL_COLOR over the new-position box with the same ordering and count, then enter DONE.
REQ-021 SHALL, in DONE, pulse done for one cycle, copy the new position to the old position, and set old-valid.
REQ-022 SHALL, with default BALL_SIZE, give update at t -> done at t+33 when old-valid, and done at t+17 otherwise.
REQ-023 SHALL compute pixel coordinates at 11-bit width and suppress plot (counter still advancing) for any pixel with x >= H_RES or y >= V_RES; no wrap-around to column/row 0.
REQ-024 SHALL, on update while busy, store the position in a one-deep pending register, overwriting any earlier pending value (latest wins).
REQ-025 SHALL, from DONE with pending set, clear pending and enter ERASE with the pending position; otherwise it SHALL enter IDLE.
REQ-026 SHALL, if update coincides with the DONE cycle, treat it as pending.
REQ-027 SHALL hold plot=0 and vga_colour=BG_COLOR in IDLE and DONE.

Reset
REQ-028 SHALL, on resetn low at any time including mid-operation, asynchronously force: state IDLE; plot, busy, done = 0; vga_x, vga_y = 0; vga_colour = BG_COLOR; old-valid and pending cleared; scan counters 0.
REQ-029 SHALL treat the first update after reset as having no old position (no erase).

Configuration
REQ-030 SHALL define macro RENDER_SKIP_SAME_EN.
REQ-031 SHALL, with RENDER_SKIP_SAME_EN defined, on update in IDLE with old-valid set and a position equal to the old position, go directly to DONE: done at t+1, no plot.
REQ-032 SHALL, without RENDER_SKIP_SAME_EN, perform a full erase and draw for identical positions.

Structure
REQ-033 SHALL take the FSM state typedef, COLOUR_W=3 and coordinate width 10 from the shared package breakout_pkg.
REQ-034 SHALL implement box scanning (dx/dy counters, last-pixel flag, restart) in one sub-module, box_scanner.

Verification
REQ-035 SHALL cover: reset, then update (100,200) -> 16 DRAW plots, x 100..103 and y 200..203 row-major in BALL_COLOR, done at t+17.
REQ-036 SHALL cover: second update (101,201) -> 16 BG_COLOR plots at 100..103/200..203, then 16 BALL_COLOR plots at 101..104/201..204, done at t+33.
REQ-037 SHALL cover: update (638,478) -> only 4 plots asserted (x 638..639, y 478..479), done still at t+17 or t+33.
REQ-038 SHALL cover: updates (10,10), (20,20), (30,30) issued during busy -> after the first done, a single redraw to (30,30) only.
REQ-039 SHALL cover: resetn low at the 5th DRAW cycle -> all outputs at reset values immediately; next update draws with no erase.
REQ-040 SHALL cover: with RENDER_SKIP_SAME_EN, a repeated identical update -> done at t+1 and zero plots.
